// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle WIDTH-bit adder/subtractor that handles CHUNK bits
// per clock, LSB chunk first, with a registered carry between chunks.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum;
  logic             r_cy, r_ovf;
  logic [IW-1:0]    r_idx;
  logic [CHUNK:0]   w_chunk;
  logic             w_last, w_cin_msb;
  int               w_base;

  // Operands shift right each RUN cycle, so the active chunk is always in the low bits.
  assign w_chunk   = {1'b0, r_opa[CHUNK-1:0]} + {1'b0, r_opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_cy};
  assign w_last    = (r_idx == IW'(NCH - 1));
  // On the last chunk the top operand bits sit at CHUNK-1; recover the carry into the MSB.
  assign w_cin_msb = r_opa[CHUNK-1] ^ r_opb[CHUNK-1] ^ w_chunk[CHUNK-1];
  assign w_base    = int'(r_idx) * CHUNK;

  assign sum   = r_sum;
  assign carry = r_cy;
  assign ovf   = r_ovf;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: IDLE -> RUN on start, RUN for NCH cycles, one DONE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one chunk per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa <= '0;
      r_opb <= '0;
      r_sum <= '0;
      r_cy  <= 1'b0;
      r_ovf <= 1'b0;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_opa <= a;
          r_opb <= mode ? ~b : b;
          r_cy  <= c ^ mode;   // subtract: borrow-in becomes inverted carry-in
          r_idx <= '0;
        end
        S_RUN: begin
          r_sum[w_base +: CHUNK] <= w_chunk[CHUNK-1:0];
          r_cy  <= w_chunk[CHUNK];
          r_opa <= r_opa >> CHUNK;
          r_opb <= r_opb >> CHUNK;
          r_idx <= r_idx + 1'b1;
          if (w_last) r_ovf <= w_cin_msb ^ w_chunk[CHUNK];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: stimulus pushes expected results computed
// with plain integer arithmetic; monitors pop and compare whenever done is seen.
module tb_chunked_addsub;
  localparam int NCH = 4;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          e0;
  } exp_t;

  exp_t q[$], qw[$], qn[$];

  // main instance: WIDTH=16, CHUNK=4
  logic        start = 0, mode = 0, c = 0;
  logic [15:0] a = 0, b = 0, sum;
  logic        carry, ovf, busy, done;
  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .c(c),
    .sum(sum), .carry(carry), .ovf(ovf), .busy(busy), .done(done));

  // single-chunk instance: WIDTH=16, CHUNK=16
  logic        w_start = 0, w_mode = 0, w_c = 0;
  logic [15:0] w_a = 0, w_b = 0, w_sum;
  logic        w_carry, w_ovf, w_busy, w_done;
  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_wide (
    .clk(clk), .rst(rst), .start(w_start), .mode(w_mode), .a(w_a), .b(w_b), .c(w_c),
    .sum(w_sum), .carry(w_carry), .ovf(w_ovf), .busy(w_busy), .done(w_done));

  // bit-serial instance: WIDTH=8, CHUNK=1
  logic       n_start = 0, n_mode = 0, n_c = 0;
  logic [7:0] n_a = 0, n_b = 0, n_sum;
  logic       n_carry, n_ovf, n_busy, n_done;
  chunked_addsub #(.WIDTH(8), .CHUNK(1)) u_narrow (
    .clk(clk), .rst(rst), .start(n_start), .mode(n_mode), .a(n_a), .b(n_b), .c(n_c),
    .sum(n_sum), .carry(n_carry), .ovf(n_ovf), .busy(n_busy), .done(n_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: w-bit integer add/subtract, signed range check for overflow.
  function automatic void model(input int w, input logic m, input logic [15:0] aa,
                                input logic [15:0] bb, input logic cc,
                                output logic [15:0] s, output logic cy, output logic ov);
    longint ua, ub, sa, sb, r, sr, one;
    one = 1;
    ua = aa; ub = bb;
    sa = aa[w-1] ? ua - (one << w) : ua;
    sb = bb[w-1] ? ub - (one << w) : ub;
    if (!m) begin r = ua + ub + cc; sr = sa + sb + cc; cy = ((r >> w) & 1) != 0; end
    else    begin r = ua - ub - cc; sr = sa - sb - cc; cy = (ua >= ub + cc);     end
    s  = 16'(r & ((one << w) - 1));
    ov = (sr < -(one << (w - 1))) || (sr >= (one << (w - 1)));
  endfunction

  // main monitor: busy/done timing every cycle, results on done
  logic eb, ed;
  always @(negedge clk) if (!rst) begin
    eb = q.size() > 0 && cyc >= q[0].e0 && cyc < q[0].e0 + NCH;
    ed = q.size() > 0 && cyc == q[0].e0 + NCH;
    chk("busy", busy, eb);
    chk("done", done, ed);
    if (done && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sum", sum, e.sum);
      chk("carry", carry, e.carry);
      chk("ovf", ovf, e.ovf);
    end
  end

  // single-chunk monitor: done one cycle after E1
  always @(negedge clk) if (!rst) begin
    chk("w_done", w_done, qw.size() > 0 && cyc == qw[0].e0 + 1);
    if (w_done && qw.size() > 0) begin
      exp_t e;
      e = qw.pop_front();
      chk("w_sum", w_sum, e.sum);
      chk("w_carry", w_carry, e.carry);
      chk("w_ovf", w_ovf, e.ovf);
    end
  end

  // bit-serial monitor: done one cycle after E8
  always @(negedge clk) if (!rst) begin
    chk("n_done", n_done, qn.size() > 0 && cyc == qn[0].e0 + 8);
    if (n_done && qn.size() > 0) begin
      exp_t e;
      e = qn.pop_front();
      chk("n_sum", n_sum, e.sum[7:0]);
      chk("n_carry", n_carry, e.carry);
      chk("n_ovf", n_ovf, e.ovf);
    end
  end

  // Issue one op; with junk=1, scramble inputs and pulse start during RUN/DONE.
  task automatic issue(input logic m, input logic [15:0] aa, input logic [15:0] bb,
                       input logic cc, input bit junk);
    exp_t e;
    @(negedge clk);
    start = 1; mode = m; a = aa; b = bb; c = cc;
    model(16, m, aa, bb, cc, e.sum, e.carry, e.ovf);
    e.e0 = cyc + 1;
    q.push_back(e);
    for (int k = 1; k <= NCH + 1; k++) begin
      @(negedge clk);
      start = junk ? 1'($urandom) : 1'b0;
      if (junk) begin a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); c = 1'($urandom); end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); start = 0; end
  endtask

  task automatic issue_w(input logic m, input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    exp_t e;
    @(negedge clk);
    w_start = 1; w_mode = m; w_a = aa; w_b = bb; w_c = cc;
    model(16, m, aa, bb, cc, e.sum, e.carry, e.ovf);
    e.e0 = cyc + 1;
    qw.push_back(e);
    @(negedge clk); w_start = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic issue_n(input logic m, input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    exp_t e;
    @(negedge clk);
    n_start = 1; n_mode = m; n_a = aa; n_b = bb; n_c = cc;
    model(8, m, {8'h0, aa}, {8'h0, bb}, cc, e.sum, e.carry, e.ovf);
    e.e0 = cyc + 1;
    qn.push_back(e);
    @(negedge clk); n_start = 0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   k0;
    // asynchronous reset, checked between edges
    #2 rst = 1;
    #1;
    chk("rst_sum", sum, 0);   chk("rst_carry", carry, 0); chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    idle(2);

    // directed arithmetic cases
    issue(0, 16'h1234, 16'h0FFF, 0, 0);
    issue(0, 16'hFFFF, 16'h0001, 0, 0);
    issue(0, 16'h7FFF, 16'h0001, 0, 0);
    issue(1, 16'h0005, 16'h0007, 0, 0);
    issue(1, 16'h8000, 16'h0001, 0, 0);
    issue(1, 16'h0010, 16'h0000, 1, 0);
    issue(1, 16'h8000, 16'h7FFF, 1, 0);
    // operand changes and start pulses while busy must be ignored
    issue(0, 16'hABCD, 16'h1357, 1, 1);
    issue(1, 16'h0F0F, 16'hF0F0, 0, 1);
    idle(2);

    // random ops, mixed modes, with and without mid-run noise
    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    idle(2);

    // start held high: accepts every NCH+2 cycles with fixed operands
    @(negedge clk);
    start = 1; mode = 0; a = 16'h4321; b = 16'h1111; c = 1;
    k0 = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      model(16, 0, 16'h4321, 16'h1111, 1, e.sum, e.carry, e.ovf);
      e.e0 = k0 + j * (NCH + 2);
      q.push_back(e);
    end
    repeat (3 * (NCH + 2) - 1) @(negedge clk);
    start = 0;
    idle(8);

    // reset while chunk 2 is in flight: outputs clear at once, no done follows
    @(negedge clk);
    start = 1; mode = 0; a = 16'h1111; b = 16'h2222; c = 0;
    model(16, 0, 16'h1111, 16'h2222, 0, e.sum, e.carry, e.ovf);
    e.e0 = cyc + 1;
    q.push_back(e);
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    q.delete();
    #1;
    chk("mid_rst_sum", sum, 0);   chk("mid_rst_carry", carry, 0); chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    idle(8);
    issue(0, 16'h0001, 16'h0001, 0, 0);
    idle(2);

    // CHUNK = WIDTH and bit-serial configurations
    issue_w(0, 16'h00FF, 16'h0000, 1);
    issue_w(1, 16'h8000, 16'h0001, 0);
    for (int i = 0; i < 4; i++) issue_w(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    issue_n(0, 8'h7F, 8'h01, 0);
    issue_n(1, 8'h03, 8'h05, 1);
    for (int i = 0; i < 4; i++) issue_n(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    idle(4);

    // every issued op must have produced exactly one done
    chk("q_drain", q.size(), 0);
    chk("qw_drain", qw.size(), 0);
    chk("qn_drain", qn.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
